muldiv_ctrl: RTL and testbench

- Multi-cycle sequencer for MIPS MULTU/DIVU, MTHI and MTLO; owns the HI/LO registers.
- Does not instantiate its own adder. It drives the shared ALU's ALUCtl/A/B/Shamt ports and consumes ALUOut, one shift-add or shift-subtract step per cycle.
- Sits beside the EX stage. The pipeline stalls on Busy.

---
 rtl/muldiv_ctrl_pkg.sv | 21 ++
 rtl/muldiv_ctrl.sv | 135 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared codes for the multiply/divide sequencer and the main decoder.
package muldiv_ctrl_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MTHI  = 2'b10,
    OP_MTLO  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_ctrl.sv
// MULTU/DIVU/MTHI/MTLO sequencer owning HI/LO; one shift-add or
// shift-subtract step per cycle through the shared ALU.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic [1:0]      Op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Hi,
  output logic [XLEN-1:0] Lo,
  output logic [3:0]      ALUCtl,
  output logic [XLEN-1:0] ALUA,
  output logic [XLEN-1:0] ALUB,
  output logic [4:0]      ALUShamt,
  input  logic [XLEN-1:0] ALUOut
);

  localparam int unsigned CW = $clog2(ITER);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  state_e          state;
  op_e             op_q;
  logic [XLEN-1:0] p, q, d;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] p_nxt, q_nxt, s;
  logic            carry, qb;

  assign ALUShamt = '0;

  always_comb begin
    ALUCtl = ALU_AND;
    ALUA   = '0;
    ALUB   = '0;
    p_nxt  = p;
    q_nxt  = q;
    s      = '0;
    carry  = 1'b0;
    qb     = 1'b0;
    if (state == RUN) begin
      if (op_q == OP_MULTU) begin
        ALUCtl = ALU_ADD;
        ALUA   = p;
        ALUB   = q[0] ? d : '0;
        carry  = (ALUOut < p);
        p_nxt  = {carry, ALUOut[XLEN-1:1]};
        q_nxt  = {ALUOut[0], q[XLEN-1:1]};
      end else begin
        // Restoring division: the bit shifted out of P forces a subtract.
        s      = {p[XLEN-2:0], q[XLEN-1]};
        ALUCtl = ALU_SUB;
        ALUA   = s;
        ALUB   = d;
        qb     = p[XLEN-1] | (s >= d);
        p_nxt  = qb ? ALUOut : s;
        q_nxt  = {q[XLEN-2:0], qb};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= OP_MULTU;
      p     <= '0;
      q     <= '0;
      d     <= '0;
      cnt   <= '0;
      Hi    <= '0;
      Lo    <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            case (op_e'(Op))
              OP_MTHI: Hi <= A;
              OP_MTLO: Lo <= A;
              OP_MULTU: begin
                op_q  <= OP_MULTU;
                p     <= '0;
                q     <= B;
                d     <= A;
                cnt   <= '0;
                state <= RUN;
                Busy  <= 1'b1;
              end
              default: begin
                op_q <= OP_DIVU;
                Busy <= 1'b1;
                if (B == '0) begin
                  Hi    <= A;
                  Lo    <= '1;
                  state <= FIN;
                  Done  <= 1'b1;
                end else begin
                  p     <= '0;
                  q     <= A;
                  d     <= B;
                  cnt   <= '0;
                  state <= RUN;
                end
              end
            endcase
          end
        end
        RUN: begin
          p   <= p_nxt;
          q   <= q_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            Hi    <= p_nxt;
            Lo    <= q_nxt;
            state <= FIN;
            Done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a behavioural shared-ALU stub.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] A = '0, B = '0;
  logic        Busy, Done;
  logic [31:0] Hi, Lo, ALUA, ALUB, ALUOut;
  logic [3:0]  ALUCtl;
  logic [4:0]  ALUShamt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (ALUCtl)
      4'b0010: ALUOut = ALUA + ALUB;
      4'b0110: ALUOut = ALUA - ALUB;
      default: ALUOut = ALUA & ALUB;
    endcase
  end

  muldiv_ctrl #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo), .ALUCtl(ALUCtl),
    .ALUA(ALUA), .ALUB(ALUB), .ALUShamt(ALUShamt), .ALUOut(ALUOut)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one command for a single edge; returns edges until Done and busy samples.
  task automatic run_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int unsigned cycles, output int unsigned busy_cnt);
    Op = op; A = a; B = b; Start = 1'b1;
    cycles = 0; busy_cnt = 0;
    tick();
    Start = 1'b0; A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D;
    cycles = 1;
    if (Busy) busy_cnt++;
    while (!Done && cycles < 100) begin
      tick();
      cycles++;
      if (Busy) busy_cnt++;
    end
  endtask

  int unsigned cyc, bsy, seen;

  initial begin
    #12;
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_done", {31'd0, Done}, 32'd0);
    check("reset_hi", Hi, 32'd0);
    check("reset_lo", Lo, 32'd0);
    check("idle_aluctl", {28'd0, ALUCtl}, 32'd0);
    check("idle_alua", ALUA, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // MULTU max*max: carry out of every step.
    Op = OP_MULTU; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; Start = 1'b1;
    tick();
    Start = 1'b0;
    check("mul_aluctl_run", {28'd0, ALUCtl}, 32'h2);
    check("mul_shamt", {27'd0, ALUShamt}, 32'd0);
    cyc = 1; bsy = 1;
    while (!Done && cyc < 100) begin
      tick(); cyc++;
      if (Busy) bsy++;
    end
    check("mul_max_latency", cyc, 32'd33);
    check("mul_max_busy_cycles", bsy, 32'd33);
    check("mul_max_hi", Hi, 32'hFFFF_FFFE);
    check("mul_max_lo", Lo, 32'h0000_0001);
    tick();
    check("mul_done_pulse", {31'd0, Done}, 32'd0);
    check("mul_busy_after", {31'd0, Busy}, 32'd0);

    run_cmd(OP_DIVU, 32'd100, 32'd7, cyc, bsy);
    check("div_100_7_latency", cyc, 32'd33);
    check("div_100_7_lo", Lo, 32'd14);
    check("div_100_7_hi", Hi, 32'd2);
    tick();

    Op = OP_DIVU; A = 32'hFFFF_FFFF; B = 32'd1; Start = 1'b1;
    tick();
    Start = 1'b0;
    check("div_aluctl_run", {28'd0, ALUCtl}, 32'h6);
    cyc = 1;
    while (!Done && cyc < 100) begin tick(); cyc++; end
    check("div_top_lo", Lo, 32'hFFFF_FFFF);
    check("div_top_hi", Hi, 32'd0);
    tick();

    run_cmd(OP_DIVU, 32'h1234_5678, 32'd0, cyc, bsy);
    check("div0_latency", cyc, 32'd1);
    check("div0_hi", Hi, 32'h1234_5678);
    check("div0_lo", Lo, 32'hFFFF_FFFF);
    tick();
    check("div0_idle", {31'd0, Busy}, 32'd0);

    // MTHI then MTLO back to back.
    seen = 0;
    Op = OP_MTHI; A = 32'hA5A5_A5A5; Start = 1'b1;
    tick();
    if (Busy || Done) seen++;
    Op = OP_MTLO; A = 32'h5A5A_5A5A;
    tick();
    if (Busy || Done) seen++;
    Start = 1'b0;
    tick();
    if (Busy || Done) seen++;
    check("mt_hi", Hi, 32'hA5A5_A5A5);
    check("mt_lo", Lo, 32'h5A5A_5A5A);
    check("mt_no_busy_done", seen, 32'd0);

    // MULTU 3*5 with an MTHI strobe arriving mid-RUN.
    Op = OP_MULTU; A = 32'd3; B = 32'd5; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (5) tick();
    Op = OP_MTHI; A = 32'h7777_7777; Start = 1'b1;
    tick();
    Start = 1'b0;
    check("mul_run_hi_held", Hi, 32'hA5A5_A5A5);
    cyc = 7;
    while (!Done && cyc < 100) begin tick(); cyc++; end
    check("mul_ignore_latency", cyc, 32'd33);
    check("mul_ignore_hi", Hi, 32'd0);
    check("mul_ignore_lo", Lo, 32'd15);
    tick();

    // Reset aborts a DIVU in flight.
    Op = OP_DIVU; A = 32'd1000; B = 32'd3; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (9) tick();
    check("abort_busy_before", {31'd0, Busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_hi", Hi, 32'd0);
    check("abort_lo", Lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (30) begin
      tick();
      if (Done) seen++;
    end
    check("abort_no_done", seen, 32'd0);

    run_cmd(OP_MULTU, 32'd6, 32'd7, cyc, bsy);
    check("mul_6_7_latency", cyc, 32'd33);
    check("mul_6_7_lo", Lo, 32'd42);
    check("mul_6_7_hi", Hi, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
